// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter_if
// Description : Bundle of the two master request/response channels and the
//               data-memory port seen by the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if #(
    parameter int AW = 12
);
    // master 0: pipeline MEM stage, single-word accesses
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata;
    logic          m0_ack;
    logic [31:0]   m0_rdata;

    // master 1: DMA/debug port, locked bursts
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [3:0]    m1_len;
    logic [31:0]   m1_wdata;
    logic          m1_ack;
    logic [31:0]   m1_rdata;
    logic          m1_done;

    // single-port data memory
    logic          dm_str;
    logic [AW-1:0] dm_a;
    logic [31:0]   dm_d;
    logic [31:0]   dm_rd;

    logic          busy;

    // arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_len, m1_wdata,
        input  dm_rd,
        output m0_ack, m0_rdata,
        output m1_ack, m1_rdata, m1_done,
        output dm_str, dm_a, dm_d,
        output busy
    );

    // masters and memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_len, m1_wdata,
        output dm_rd,
        input  m0_ack, m0_rdata,
        input  m1_ack, m1_rdata, m1_done,
        input  dm_str, dm_a, dm_d,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin arbiter/sequencer between the MEM stage (master 0)
//               and a burst DMA/debug port (master 1) in front of the
//               single-port data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int AW        = 12,
    parameter int MAX_BURST = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    dm_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S0   = 2'd1;
    localparam logic [1:0] ST_S1   = 2'd2;

    localparam logic [4:0] MAXB     = 5'(MAX_BURST);
    localparam logic [3:0] LEN_CLMP = 4'(MAX_BURST - 1);

    logic [1:0] state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] len_eff;
    logic       last_beat;

    // Winner selection: a lone requester wins; on a tie the master that was
    // not served last wins (lg=1 means master 1 was served last).
    function automatic logic [1:0] pick(input logic r0, input logic r1, input logic lg);
        if (r0 && r1)
            return lg ? ST_S0 : ST_S1;
        else if (r0)
            return ST_S0;
        else if (r1)
            return ST_S1;
        else
            return ST_IDLE;
    endfunction

    // Clamp oversized burst lengths and flag the final beat.
    always_comb begin
        len_eff   = ({1'b0, bus.m1_len} >= MAXB) ? LEN_CLMP : bus.m1_len;
        last_beat = (state_q == ST_S1) && (cnt_q == len_eff);
    end

    // Next-state logic. The request of the master being served this cycle
    // is consumed by its ack; if it stays high it is seen as a new request
    // in the following cycle.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = 4'd0;
        case (state_q)
            ST_IDLE: state_d = pick(bus.m0_req, bus.m1_req, last_gnt_q);
            ST_S0: begin
                last_gnt_d = 1'b0;
                state_d    = pick(1'b0, bus.m1_req, 1'b0);
            end
            ST_S1: begin
                if (last_beat) begin
                    last_gnt_d = 1'b1;
                    state_d    = pick(bus.m0_req, 1'b0, 1'b1);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, fairness and beat-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory port and master responses; everything is forced low while rst
    // is high so an abandoned burst never stores in the reset cycle.
    always_comb begin
        bus.m0_ack   = 1'b0;
        bus.m0_rdata = 32'd0;
        bus.m1_ack   = 1'b0;
        bus.m1_rdata = 32'd0;
        bus.m1_done  = 1'b0;
        bus.dm_str   = 1'b0;
        bus.dm_a     = '0;
        bus.dm_d     = 32'd0;
        bus.busy     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_S0: begin
                    bus.busy     = 1'b1;
                    bus.dm_a     = bus.m0_addr;
                    bus.dm_d     = bus.m0_wdata;
                    bus.dm_str   = bus.m0_we;
                    bus.m0_ack   = 1'b1;
                    bus.m0_rdata = bus.dm_rd;
                end
                ST_S1: begin
                    bus.busy     = 1'b1;
                    bus.dm_a     = bus.m1_addr + AW'(cnt_q);
                    bus.dm_d     = bus.m1_wdata;
                    bus.dm_str   = bus.m1_we;
                    bus.m1_ack   = 1'b1;
                    bus.m1_rdata = bus.dm_rd;
                    bus.m1_done  = last_beat;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Directed self-checking bench for dm_arbiter with a 4K-word
//               behavioural data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   n_pass;
    int   n_chk;

    dm_arbiter_if #(.AW(12)) bus ();

    dm_arbiter #(.AW(12), .MAX_BURST(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the clock edge.
    logic [31:0] mem [0:4095];
    assign bus.dm_rd = mem[bus.dm_a];

    // Memory write port with a one-shot clear at start of simulation.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
        end else if (bus.dm_str) begin
            mem[bus.dm_a] <= bus.dm_d;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {27'd0, bus.m0_ack, bus.m1_ack, bus.m1_done, bus.dm_str, bus.busy}, 32'd0);
        chk({tag, "_bus"}, {20'd0, bus.dm_a} | bus.dm_d | bus.m0_rdata | bus.m1_rdata, 32'd0);
    endtask

    // Single master-0 access issued from an idle cycle; returns in an idle cycle.
    task automatic m0_access(input string tag, input logic we, input logic [11:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
        bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        nxt(); settle();
        chk({tag, "_ack"}, {29'd0, bus.m0_ack, bus.m1_ack, bus.dm_str}, {29'd0, 1'b1, 1'b0, we});
        chk({tag, "_a"}, {20'd0, bus.dm_a}, {20'd0, addr});
        chk({tag, "_rd"}, bus.m0_rdata, exp_rd);
        nxt(); bus.m0_req = 1'b0; settle();
        chk_idle({tag, "_end"});
    endtask

    logic [11:0] t3_a [4];
    logic [31:0] t5_rd [6];

    initial begin
        n_pass = 0; n_chk = 0;
        t3_a[0] = 12'hFFE; t3_a[1] = 12'hFFF; t3_a[2] = 12'h000; t3_a[3] = 12'h001;
        t5_rd[0] = 32'h11; t5_rd[1] = 32'h22; t5_rd[2] = 32'h0;
        t5_rd[3] = 32'h0;  t5_rd[4] = 32'h0;  t5_rd[5] = 32'h0;
        rst = 1'b1; clr = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_len = '0; bus.m1_wdata = '0;

        // ---- reset, single write then read-back by master 0
        nxt(); clr = 1'b0; settle();
        chk_idle("rst_cyc");
        nxt(); rst = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h010; bus.m0_wdata = 32'hDEADBEEF;
        settle();
        chk_idle("post_rst");
        nxt(); settle();
        chk("t1_ack", {29'd0, bus.m0_ack, bus.m1_ack, bus.dm_str}, 32'b101);
        chk("t1_a", {20'd0, bus.dm_a}, 32'h010);
        chk("t1_d", bus.dm_d, 32'hDEADBEEF);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        nxt(); bus.m0_req = 1'b0; settle();
        chk_idle("t1_gap");
        m0_access("t1_rd", 1'b0, 12'h010, 32'h0, 32'hDEADBEEF);

        // ---- simultaneous requests after reset: m0, m1, m0, m1
        rst = 1'b1;
        nxt(); rst = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h020; bus.m0_wdata = 32'hA0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 12'h030; bus.m1_len = 4'd0; bus.m1_wdata = 32'hB0;
        settle();
        chk_idle("t2_idle");
        nxt(); settle();
        chk("t2_c1", {29'd0, bus.m0_ack, bus.m1_ack, bus.m1_done}, 32'b100);
        chk("t2_c1a", {20'd0, bus.dm_a}, 32'h020);
        nxt(); settle();
        chk("t2_c2", {29'd0, bus.m0_ack, bus.m1_ack, bus.m1_done}, 32'b011);
        chk("t2_c2a", {20'd0, bus.dm_a}, 32'h030);
        nxt(); settle();
        chk("t2_c3", {29'd0, bus.m0_ack, bus.m1_ack, bus.m1_done}, 32'b100);
        nxt(); bus.m0_req = 1'b0; settle();
        chk("t2_c4", {29'd0, bus.m0_ack, bus.m1_ack, bus.m1_done}, 32'b011);
        nxt(); bus.m1_req = 1'b0; settle();
        chk_idle("t2_end");

        // ---- wrapping write burst at the top of memory, then read back
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 12'hFFE; bus.m1_len = 4'd3; bus.m1_wdata = 32'd1;
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i > 0) bus.m1_wdata = 32'(i + 1);
            settle();
            chk($sformatf("t3_w_a%0d", i), {20'd0, bus.dm_a}, {20'd0, t3_a[i]});
            chk($sformatf("t3_w_c%0d", i), {29'd0, bus.m1_ack, bus.m1_done, bus.dm_str},
                {29'd0, 1'b1, (i == 3), 1'b1});
            chk($sformatf("t3_w_d%0d", i), bus.dm_d, 32'(i + 1));
        end
        nxt(); bus.m1_req = 1'b0; settle();
        chk_idle("t3_w_end");
        bus.m1_req = 1'b1; bus.m1_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt(); settle();
            chk($sformatf("t3_r_c%0d", i), {29'd0, bus.m1_ack, bus.m1_done, bus.dm_str},
                {29'd0, 1'b1, (i == 3), 1'b0});
            chk($sformatf("t3_r_d%0d", i), bus.m1_rdata, 32'(i + 1));
        end
        nxt(); bus.m1_req = 1'b0; settle();
        chk_idle("t3_r_end");

        // ---- master 0 requests during an 8-beat locked burst
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'h100; bus.m1_len = 4'd7;
        for (int i = 0; i < 8; i++) begin
            nxt();
            if (i == 1) begin
                bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h200; bus.m0_wdata = 32'h55;
            end
            settle();
            chk($sformatf("t4_c%0d", i), {29'd0, bus.m0_ack, bus.m1_ack, bus.m1_done},
                {29'd0, 1'b0, 1'b1, (i == 7)});
            chk($sformatf("t4_a%0d", i), {20'd0, bus.dm_a}, 32'h100 + 32'(i));
            chk($sformatf("t4_r0_%0d", i), bus.m0_rdata, 32'd0);
        end
        nxt(); bus.m1_req = 1'b0; settle();
        chk("t4_m0", {29'd0, bus.m0_ack, bus.m1_ack, bus.dm_str}, 32'b101);
        chk("t4_m0a", {20'd0, bus.dm_a}, 32'h200);
        chk("t4_r1", bus.m1_rdata, 32'd0);
        nxt(); bus.m0_req = 1'b0; settle();
        chk_idle("t4_end");

        // ---- reset on the third beat of a 6-beat write burst
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 12'h300; bus.m1_len = 4'd5; bus.m1_wdata = 32'h11;
        nxt(); settle();
        chk("t5_b0", {20'd0, bus.dm_a}, 32'h300);
        nxt(); bus.m1_wdata = 32'h22; settle();
        chk("t5_b1", {20'd0, bus.dm_a}, 32'h301);
        nxt(); bus.m1_wdata = 32'h33; rst = 1'b1; settle();
        chk_idle("t5_rst");
        nxt(); rst = 1'b0; bus.m1_req = 1'b0; settle();
        chk_idle("t5_post");
        for (int i = 0; i < 6; i++)
            m0_access($sformatf("t5_rd%0d", i), 1'b0, 12'h300 + 12'(i), 32'h0, t5_rd[i]);

        // ---- oversized length is clamped to 8 beats
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'h400; bus.m1_len = 4'd15;
        for (int i = 0; i < 8; i++) begin
            nxt(); settle();
            chk($sformatf("t6_c%0d", i), {30'd0, bus.m1_ack, bus.m1_done}, {30'd0, 1'b1, (i == 7)});
        end
        nxt(); bus.m1_req = 1'b0; settle();
        chk_idle("t6_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
